// File: rtl/ysyx_24100012_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100012_pkg
// Description : Shared decode constants for the NPC decode stage: RV32I
//               opcodes, ALU operation selects, the instruction-kind enum
//               and the registered decode payload layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100012_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU select: bit 3 picks the "alternate" op (sub / sra), bits 2:0
    // follow funct3 so register and immediate forms map directly.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [2:0] {
        KIND_ALU    = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JAL    = 3'd4,
        KIND_JALR   = 3'd5
    } kind_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu_sel;
        logic [4:0]  rd;
        logic        wen;
        kind_e       kind;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [31:0] store_data;
        logic [31:0] pc;
        logic        illegal;
    } payload_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100012_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100012_imm_gen
// Description : Combinational RV32I immediate extraction. Produces all five
//               sign-extended immediate formats from one instruction word.
// Ports       : i_inst    - instruction bits 31:7 (opcode is not needed)
//               o_imm_i/s/b/u/j - I, S, B, U and J format immediates
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100012_imm_gen (
    input  logic [31:7] i_inst,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_s,
    output logic [31:0] o_imm_b,
    output logic [31:0] o_imm_u,
    output logic [31:0] o_imm_j
);

    always_comb begin
        o_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
        o_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        o_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
        o_imm_u = {i_inst[31:12], 12'b0};
        o_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_24100012_idu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100012_idu
// Description : RV32I decode and operand-select stage feeding the ALU.
//               Accepts one instruction per valid/ready handshake, decodes
//               it against the combinational regfile read data and holds
//               the result in a single payload register.
// Ports       : clk, rst (async, active-low), flush (redirect)
//               in_valid/in_ready, in_inst, in_pc     - fetch side
//               rs1_addr/rs2_addr, rs1_data/rs2_data  - regfile read ports
//               out_valid/out_ready and out_*         - execute side
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100012_idu
    import ysyx_24100012_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic [4:0]            rs1_addr,
    output logic [4:0]            rs2_addr,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [3:0]            out_alu_sel,
    output logic [4:0]            out_rd,
    output logic                  out_wen,
    output logic [2:0]            out_kind,
    output logic [2:0]            out_funct3,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [DATA_WIDTH-1:0] out_store_data,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic                  out_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_shamt;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_legal;
    logic        w_writes;
    logic        w_accept;
    payload_t    w_pl;
    payload_t    r_pl;
    logic        r_valid;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];
    assign w_shamt  = {27'b0, in_inst[24:20]};
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    ysyx_24100012_imm_gen u_imm_gen (
        .i_inst  (in_inst[31:7]),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_u (w_imm_u),
        .o_imm_j (w_imm_j)
    );

    always_comb begin
        w_pl            = '0;
        w_pl.rd         = w_rd;
        w_pl.funct3     = w_funct3;
        w_pl.store_data = rs2_data;
        w_pl.pc         = in_pc;
        w_pl.alu_sel    = ALU_ADD;
        w_pl.kind       = KIND_ALU;
        w_legal         = 1'b1;
        w_writes        = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_pl.a       = rs1_data;
                w_pl.b       = rs2_data;
                w_pl.alu_sel = {in_inst[30], w_funct3};
                // inst[30] is only meaningful for sub and sra.
                w_legal      = (w_funct7 == 7'h00) ||
                               ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
                w_writes     = 1'b1;
            end
            OPC_OP_IMM: begin
                w_pl.a       = rs1_data;
                w_pl.b       = w_imm_i;
                w_pl.imm     = w_imm_i;
                w_pl.alu_sel = {1'b0, w_funct3};
                w_writes     = 1'b1;
                if (w_funct3 == 3'b001) begin
                    w_pl.b       = w_shamt;
                    w_pl.alu_sel = ALU_SLL;
                    w_legal      = (w_funct7 == 7'h00);
                end else if (w_funct3 == 3'b101) begin
                    w_pl.b       = w_shamt;
                    w_pl.alu_sel = in_inst[30] ? ALU_SRA : ALU_SRL;
                    w_legal      = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                end
            end
            OPC_LUI: begin
                w_pl.b   = w_imm_u;
                w_pl.imm = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                w_pl.a   = in_pc;
                w_pl.b   = w_imm_u;
                w_pl.imm = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_JAL: begin
                // ALU computes the link address; the target uses imm.
                w_pl.a    = in_pc;
                w_pl.b    = 32'd4;
                w_pl.imm  = w_imm_j;
                w_pl.kind = KIND_JAL;
                w_writes  = 1'b1;
            end
            OPC_JALR: begin
                w_pl.a    = in_pc;
                w_pl.b    = 32'd4;
                w_pl.imm  = w_imm_i;
                w_pl.kind = KIND_JALR;
                w_writes  = 1'b1;
            end
            OPC_LOAD: begin
                w_pl.a    = rs1_data;
                w_pl.b    = w_imm_i;
                w_pl.imm  = w_imm_i;
                w_pl.kind = KIND_LOAD;
                w_writes  = 1'b1;
            end
            OPC_STORE: begin
                w_pl.a    = rs1_data;
                w_pl.b    = w_imm_s;
                w_pl.imm  = w_imm_s;
                w_pl.kind = KIND_STORE;
            end
            OPC_BRANCH: begin
                w_pl.a    = rs1_data;
                w_pl.b    = rs2_data;
                w_pl.imm  = w_imm_b;
                w_pl.kind = KIND_BRANCH;
                case (w_funct3[2:1])
                    2'b00:   w_pl.alu_sel = ALU_SUB;
                    2'b10:   w_pl.alu_sel = ALU_SLT;
                    2'b11:   w_pl.alu_sel = ALU_SLTU;
                    default: w_legal      = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_pl.alu_sel = ALU_ADD;
            w_pl.kind    = KIND_ALU;
        end
        w_pl.illegal = !w_legal;
        w_pl.wen     = w_writes && w_legal && (w_rd != 5'd0);
    end

    // flush blocks acceptance so a redirected-away instruction is never taken.
    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_pl    <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_pl <= w_pl;
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_a          = r_pl.a;
    assign out_b          = r_pl.b;
    assign out_alu_sel    = r_pl.alu_sel;
    assign out_rd         = r_pl.rd;
    assign out_wen        = r_pl.wen;
    assign out_kind       = r_pl.kind;
    assign out_funct3     = r_pl.funct3;
    assign out_imm        = r_pl.imm;
    assign out_store_data = r_pl.store_data;
    assign out_pc         = r_pl.pc;
    assign out_illegal    = r_pl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100012_idu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24100012_idu
// Description : Self-checking bench for the decode stage: directed vector
//               table, handshake corner sequences and randomized traffic
//               checked against an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100012_idu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        in_ready, out_valid, out_wen, out_illegal;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    logic [3:0]  out_alu_sel;
    logic [2:0]  out_kind, out_funct3;
    logic [31:0] out_a, out_b, out_imm, out_store_data, out_pc;

    int checks = 0;
    int errors = 0;

    ysyx_24100012_idu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_sel(out_alu_sel), .out_rd(out_rd),
        .out_wen(out_wen), .out_kind(out_kind), .out_funct3(out_funct3), .out_imm(out_imm),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wen;
        logic [2:0]  kind;
        logic [31:0] imm;
        logic        ill;
        logic        chk_imm;
        logic [2:0]  f3;
        logic [31:0] store;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        wen;
        logic [2:0]  kind;
        logic [31:0] imm;
        logic        ill;
        logic        chk_imm;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_payload(input string tag, input exp_t e);
        chk({tag, " valid"},   32'(out_valid),   32'd1);
        chk({tag, " sel"},     32'(out_alu_sel), 32'(e.sel));
        chk({tag, " rd"},      32'(out_rd),      32'(e.rd));
        chk({tag, " wen"},     32'(out_wen),     32'(e.wen));
        chk({tag, " kind"},    32'(out_kind),    32'(e.kind));
        chk({tag, " illegal"}, 32'(out_illegal), 32'(e.ill));
        chk({tag, " funct3"},  32'(out_funct3),  32'(e.f3));
        chk({tag, " store"},   out_store_data,   e.store);
        chk({tag, " pc"},      out_pc,           e.pc);
        if (!e.ill) begin
            chk({tag, " a"}, out_a, e.a);
            chk({tag, " b"}, out_b, e.b);
        end
        if (e.chk_imm) chk({tag, " imm"}, out_imm, e.imm);
    endtask

    // Instruction-level reference: immediates via signed arithmetic, ops by mnemonic.
    function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] x1, input logic [31:0] x2);
        exp_t e;
        logic signed [31:0] s;
        logic [31:0] i_imm, s25, s31, s_imm, b_imm, u_imm, j_imm, shamt;
        logic [6:0] f7;
        logic [2:0] f3;
        logic ok, wr;
        s     = i;
        i_imm = s >>> 20;
        s25   = s >>> 25;
        s31   = s >>> 31;
        s_imm = (s25 << 5) | 32'(i[11:7]);
        b_imm = (s31 << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        u_imm = i & 32'hFFFF_F000;
        j_imm = (s31 << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        shamt = 32'(i[24:20]);
        f7 = i[31:25];
        f3 = i[14:12];
        e = '{a: 0, b: 0, sel: 0, rd: i[11:7], wen: 0, kind: 0, imm: 0, ill: 0,
              chk_imm: 0, f3: f3, store: x2, pc: pc};
        ok = 1'b1;
        wr = 1'b0;
        case (i[6:0])
            7'h33: begin
                e.a = x1; e.b = x2; wr = 1'b1;
                if (f7 == 7'h00) e.sel = {1'b0, f3};
                else if (f7 == 7'h20 && f3 == 3'd0) e.sel = 4'd8;
                else if (f7 == 7'h20 && f3 == 3'd5) e.sel = 4'd13;
                else ok = 1'b0;
            end
            7'h13: begin
                e.a = x1; wr = 1'b1;
                if (f3 == 3'd1) begin
                    e.b = shamt; e.sel = 4'd1; ok = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    e.b = shamt;
                    e.sel = (f7 == 7'h20) ? 4'd13 : 4'd5;
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                end else begin
                    e.b = i_imm; e.sel = {1'b0, f3};
                end
            end
            7'h37: begin e.b = u_imm; wr = 1'b1; end
            7'h17: begin e.a = pc; e.b = u_imm; wr = 1'b1; end
            7'h6F: begin e.a = pc; e.b = 4; e.imm = j_imm; e.kind = 4; wr = 1'b1; end
            7'h67: begin e.a = pc; e.b = 4; e.imm = i_imm; e.kind = 5; wr = 1'b1; end
            7'h03: begin e.a = x1; e.b = i_imm; e.kind = 1; wr = 1'b1; end
            7'h23: begin e.a = x1; e.b = s_imm; e.kind = 2; end
            7'h63: begin
                e.a = x1; e.b = x2; e.imm = b_imm; e.kind = 3;
                if (f3 == 3'd0 || f3 == 3'd1) e.sel = 4'd8;
                else if (f3 == 3'd4 || f3 == 3'd5) e.sel = 4'd2;
                else if (f3 == 3'd6 || f3 == 3'd7) e.sel = 4'd3;
                else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.sel  = 4'd0;
            e.kind = 3'd0;
        end
        e.ill     = !ok;
        e.wen     = wr && ok && (e.rd != 5'd0);
        e.chk_imm = ok && (e.kind >= 3'd3);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] i;
        logic [6:0]  opcs [9];
        int r;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63};
        i = $urandom;
        r = int'($urandom_range(0, 10));
        if (r < 9) i[6:0] = opcs[r];
        r = int'($urandom_range(0, 3));
        if (r == 0) i[31:25] = 7'h00;
        else if (r == 1) i[31:25] = 7'h20;
        return i;
    endfunction

    vec_t vecs [16];
    exp_t e;
    exp_t exp_pl;
    logic exp_valid;
    logic exp_ready;
    logic acc;

    initial begin
        vecs[0]  = '{32'h002081B3, 32'h80000000, 32'd5,        32'd7,    32'd5,        32'd7,        4'h0, 5'd3,  1'b1, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{32'h402081B3, 32'h80000004, 32'd10,       32'd3,    32'd10,       32'd3,        4'h8, 5'd3,  1'b1, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{32'h40335293, 32'h80000008, 32'h80000000, 32'd0,    32'h80000000, 32'd3,        4'hD, 5'd5,  1'b1, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{32'h123450B7, 32'h8000000C, 32'hDEAD,     32'hBEEF, 32'h0,        32'h12345000, 4'h0, 5'd1,  1'b1, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{32'hFE20CCE3, 32'h80000010, 32'd1,        32'd2,    32'd1,        32'd2,        4'h2, 5'd25, 1'b0, 3'd3, 32'hFFFFFFF8, 1'b0, 1'b1};
        vecs[5]  = '{32'h0000007F, 32'h80000014, 32'd1,        32'd2,    32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b1, 1'b0};
        vecs[6]  = '{32'h00208033, 32'h80000018, 32'd4,        32'd6,    32'd4,        32'd6,        4'h0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{32'h010000EF, 32'h80000020, 32'd1,        32'd2,    32'h80000020, 32'd4,        4'h0, 5'd1,  1'b1, 3'd4, 32'd16,       1'b0, 1'b1};
        vecs[8]  = '{32'h008100E7, 32'h80000024, 32'd1,        32'd2,    32'h80000024, 32'd4,        4'h0, 5'd1,  1'b1, 3'd5, 32'd8,        1'b0, 1'b1};
        vecs[9]  = '{32'h0020A623, 32'h80000028, 32'h100,      32'd77,   32'h100,      32'd12,       4'h0, 5'd12, 1'b0, 3'd2, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{32'hFFC0A283, 32'h8000002C, 32'h200,      32'd0,    32'h200,      32'hFFFFFFFC, 4'h0, 5'd5,  1'b1, 3'd1, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{32'h00001397, 32'h80000040, 32'd0,        32'd0,    32'h80000040, 32'h1000,     4'h0, 5'd7,  1'b1, 3'd0, 32'h0,        1'b0, 1'b0};
        vecs[12] = '{32'h402091B3, 32'h80000044, 32'd1,        32'd2,    32'd0,        32'd0,        4'h0, 5'd3,  1'b0, 3'd0, 32'h0,        1'b1, 1'b0};
        vecs[13] = '{32'h00002063, 32'h80000048, 32'd1,        32'd2,    32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b1, 1'b0};
        vecs[14] = '{32'h40001013, 32'h8000004C, 32'd1,        32'd2,    32'd0,        32'd0,        4'h0, 5'd0,  1'b0, 3'd0, 32'h0,        1'b1, 1'b0};
        vecs[15] = '{32'h00208463, 32'h80000050, 32'd3,        32'd3,    32'd3,        32'd3,        4'h8, 5'd8,  1'b0, 3'd3, 32'd8,        1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid",   32'(out_valid),   32'd0);
        chk("reset a",       out_a,            32'd0);
        chk("reset sel",     32'(out_alu_sel), 32'd0);
        chk("reset illegal", 32'(out_illegal), 32'd0);
        chk("reset pc",      out_pc,           32'd0);
        rst = 1'b1;

        // Directed vector table
        for (int k = 0; k < 16; k++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_inst   = vecs[k].inst;
            in_pc     = vecs[k].pc;
            rs1_data  = vecs[k].x1;
            rs2_data  = vecs[k].x2;
            #1;
            chk($sformatf("vec%0d in_ready", k), 32'(in_ready), 32'd1);
            if (k == 0) begin
                chk("vec0 rs1_addr", 32'(rs1_addr), 32'd1);
                chk("vec0 rs2_addr", 32'(rs2_addr), 32'd2);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            e = '{a: vecs[k].a, b: vecs[k].b, sel: vecs[k].sel, rd: vecs[k].rd, wen: vecs[k].wen,
                  kind: vecs[k].kind, imm: vecs[k].imm, ill: vecs[k].ill, chk_imm: vecs[k].chk_imm,
                  f3: vecs[k].inst[14:12], store: vecs[k].x2, pc: vecs[k].pc};
            cmp_payload($sformatf("vec%0d", k), e);
        end

        // Backpressure: hold, then consume-and-accept in the same cycle
        in_valid = 1'b1; out_ready = 1'b1;
        in_inst = 32'h002081B3; in_pc = 32'h100; rs1_data = 32'h11; rs2_data = 32'h22;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_inst = 32'h123450B7; rs1_data = 32'h99; rs2_data = 32'h98;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d a", c), out_a, 32'h11);
            chk($sformatf("bp%0d b", c), out_b, 32'h22);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp new valid", 32'(out_valid), 32'd1);
        chk("bp new a",     out_a,          32'd0);
        chk("bp new b",     out_b,          32'h12345000);

        // Flush with a held payload and an incoming instruction
        out_ready = 1'b0; flush = 1'b1;
        in_inst = 32'h002081B3; rs1_data = 32'h55; rs2_data = 32'h66;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush valid",  32'(out_valid), 32'd0);
        chk("flush no cap", out_b,          32'h12345000);

        // Asynchronous reset mid-stream
        in_valid = 1'b1; out_ready = 1'b1;
        in_inst = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre-rst valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst valid", 32'(out_valid),   32'd0);
        chk("rst a",     out_a,            32'd0);
        chk("rst b",     out_b,            32'd0);
        chk("rst sel",   32'(out_alu_sel), 32'd0);
        chk("rst rd",    32'(out_rd),      32'd0);
        chk("rst pc",    out_pc,           32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the reference model
        @(posedge clk); #1;
        exp_valid = 1'b0;
        exp_pl = '{a: 0, b: 0, sel: 0, rd: 0, wen: 0, kind: 0, imm: 0, ill: 0,
                   chk_imm: 0, f3: 0, store: 0, pc: 0};
        for (int n = 0; n < 400; n++) begin
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_inst   = gen_inst();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            #1;
            exp_ready = !flush && (!exp_valid || out_ready);
            chk($sformatf("rnd%0d in_ready", n), 32'(in_ready), 32'(exp_ready));
            acc = in_valid && exp_ready;
            if (acc) exp_pl = ref_model(in_inst, in_pc, rs1_data, rs2_data);
            if (flush) exp_valid = 1'b0;
            else if (acc) exp_valid = 1'b1;
            else if (out_ready) exp_valid = 1'b0;
            @(posedge clk); #1;
            if (exp_valid) cmp_payload($sformatf("rnd%0d", n), exp_pl);
            else chk($sformatf("rnd%0d valid", n), 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_24100012_idu.md
# ysyx_24100012_idu

Decode-and-operand-select stage directly upstream of the ALU in the single-issue RV32I NPC core. It accepts one fetched instruction per handshake, reads two register-file ports, decodes the instruction, and builds the ALU's two operands and 4-bit operation select. The result is held in one pipeline register with a valid/ready handshake. Its outputs drive the ALU inputs `in_a`, `in_b` and `alu_sel` one-to-one, plus sideband for memory and writeback.

## Interface
- `DATA_WIDTH`, 32: datapath width; only 32 is supported.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  drop held and incoming instruction (redirect).
- `in_valid`  in  1  fetch presents `in_inst` / `in_pc`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  32  its PC.
- `rs1_addr`, `rs2_addr`  out  5  combinational regfile read addresses: `in_inst[19:15]` and `in_inst[24:20]`.
- `rs1_data`, `rs2_data`  in  32  combinational regfile read data.
- `out_valid`  out  1  payload valid.
- `out_ready`  in  1  execute consumes payload.
- `out_a`, `out_b`  out  32  ALU operands.
- `out_alu_sel`  out  4  ALU op: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- `out_rd`  out  5  destination register.
- `out_wen`  out  1  writeback enable.
- `out_kind`  out  3  ALU, LOAD, STORE, BRANCH, JAL, JALR.
- `out_funct3`  out  3  raw funct3, for memory size or branch condition.
- `out_imm`  out  32  sign-extended immediate, used for branch/jump target and JALR base offset.
- `out_store_data`  out  32  `rs2_data`.
- `out_pc`  out  32  instruction PC.
- `out_illegal`  out  1  unsupported encoding.

## Operation
Decode rules, by opcode:
- OP (0110011): a=rs1, b=rs2, sel={inst[30],funct3}.
  - Legal only if funct7 is 0x00, or funct7 is 0x20 with funct3 000 or 101.
- OP-IMM (0010011): a=rs1, b=imm_I, sel={0,funct3}.
- OP-IMM shifts (funct3 001/101): b={27'b0, inst[24:20]}.
  - srai sets sel[3]=inst[30].
  - slli requires inst[31:25]=0; srli/srai require inst[31:25] of 0x00 or 0x20.
- LUI: a=0, b=imm_U, add.
- AUIPC: a=pc, b=imm_U, add.
- JAL: a=pc, b=4, add; imm=imm_J.
- JALR: a=pc, b=4, add; imm=imm_I.
- LOAD: a=rs1, b=imm_I, add.
- STORE: a=rs1, b=imm_S, add; wen=0.
- BRANCH: a=rs1, b=rs2; wen=0; imm=imm_B.
  - beq/bne use sub (1000); blt/bge use slt (0010); bltu/bgeu use sltu (0011).
  - funct3 010/011 are illegal.

Common rules:
- `out_wen`=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, and is forced 0 when rd=0.
- Any other opcode or illegal funct combination: `out_illegal`=1, wen=0, sel=add, kind=ALU.
- Immediates are sign-extended from inst[31]; imm_U = {inst[31:12], 12'b0}.

## Timing
- Latency 1: an instruction accepted at edge N is on the outputs after edge N.
- `in_ready` = !flush && (!out_valid || out_ready).
- Acceptance occurs on in_valid && in_ready.
- Payload register: loads on acceptance; otherwise it holds, stable and unchanged, while out_valid && !out_ready.
- out_valid next-state rules:
  - flush → 0.
  - Else acceptance → 1.
  - Else out_ready → 0.
- Simultaneous consume and accept gives back-to-back throughput of one instruction per cycle.
- flush has priority over everything: the held payload is dropped and the incoming instruction is not accepted.
- Reset, also mid-handshake: out_valid=0 and every payload output is 0, including out_alu_sel=0000 and out_illegal=0. This takes effect immediately, independent of clk.
- rs1/rs2 data are sampled at the acceptance edge; no bypass is done here.

## Structure
- Package `ysyx_24100012_pkg` holds:
  - opcode constants;
  - ALU select constants (ALU_ADD … ALU_AND, matching the encoding above);
  - the `out_kind` enum.
- Sub-module `ysyx_24100012_imm_gen`: combinational, inst → imm_I/S/B/U/J.
- Top: combinational decode plus one registered payload with a valid bit.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle a=5, b=7, sel=0000, rd=3, wen=1, kind=ALU.
- sub (0x402081B3) → sel=1000. srai x5,x6,3 (0x40335293), rs1=0x80000000 → b=3, sel=1101, rd=5.
- lui x1,0x12345 (0x123450B7) → a=0, b=0x12345000. blt x1,x2,-8 (0xFE20CCE3) → sel=0010, wen=0, imm=0xFFFFFFF8, kind=BRANCH.
- Backpressure: hold out_ready=0 with out_valid=1 for 3 cycles → in_ready=0, payload unchanged. Then raise out_ready with in_valid=1 → a new payload appears the next cycle and out_valid stays 1.
- flush with out_valid=1 and in_valid=1 → out_valid=0 next cycle, no capture, in_ready=0 during flush.
- Drop `rst` mid-stream → all outputs 0 immediately. Opcode 0x7F, or add with rd=0 → illegal=1 / wen=0 respectively.
